// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared width encodings, state type and lane-count helper for memory_stage
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10,
    DONE     = 2'b11
  } mem_state_t;

  function automatic int mem_nbytes(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// rtl/memory_stage_load_align.sv - load_align: picks the addressed lane of a read word and extends it
// Purely combinational so the cache refill path can share it.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [1:0]      width,
  input  logic            sign_extend,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[8*offset +: 8];
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    unique case (width)
      MEM_BYTE: data = {{(XLEN-8){sign_extend & lane_b[7]}}, lane_b};
      MEM_HALF: data = {{(XLEN-16){sign_extend & lane_h[15]}}, lane_h};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store unit with valid/ready data-memory port and lane alignment
// Optional misalignment trap: MEMORY_STAGE_MISALIGN_TRAP_EN.
module memory_stage
  import mem_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int NBYTES = mem_nbytes(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic              mem_write_en,
  input  logic              mem_read_en,
  input  logic [1:0]        mem_width,
  input  logic              sign_extend,
  input  logic [4:0]        rd_in,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_we,
  output logic [NBYTES-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   result,
  output logic [4:0]        rd_out,
  output logic              misaligned
);

  mem_state_t        state, state_next;
  logic [XLEN-1:0]   addr_q, wdata_q, result_q, load_value;
  logic [NBYTES-1:0] wstrb_q, wstrb_in;
  logic [XLEN-1:0]   wdata_in;
  logic [1:0]        offset_in, offset_q, width_q;
  logic [4:0]        rd_q, rd_out_q;
  logic              we_q, sign_q;
  logic              accept, is_mem, trap;

  assign accept = in_valid && (state == IDLE);
  assign is_mem = mem_read_en | mem_write_en;

  // Low address bits are forced to the natural alignment of the access size.
  always_comb begin
    offset_in = 2'b00;
    wstrb_in  = '0;
    wdata_in  = store_data;
    unique case (mem_width)
      MEM_BYTE: begin
        offset_in = addr[1:0];
        wstrb_in  = NBYTES'(4'b0001) << offset_in;
        wdata_in  = {4{store_data[7:0]}};
      end
      MEM_HALF: begin
        offset_in = {addr[1], 1'b0};
        wstrb_in  = NBYTES'(4'b0011) << offset_in;
        wdata_in  = {2{store_data[15:0]}};
      end
      default: begin
        offset_in = 2'b00;
        wstrb_in  = '1;
        wdata_in  = store_data;
      end
    endcase
    if (!mem_write_en) wstrb_in = '0;
  end

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign trap = is_mem &&
                (((mem_width == MEM_HALF) && addr[0]) ||
                 (mem_width[1] && (addr[1:0] != 2'b00)));

  always_ff @(posedge clk) begin
    if (rst)         misaligned_q <= 1'b0;
    else if (accept) misaligned_q <= trap;
  end

  assign misaligned = misaligned_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    dmem_req_valid = 1'b0;
    out_valid      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (is_mem && !trap) ? REQ : DONE;
      end
      REQ: begin
        dmem_req_valid = !rst;
        if (dmem_req_ready) state_next = we_q ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (dmem_rdata),
    .offset      (offset_q),
    .width       (width_q),
    .sign_extend (sign_q),
    .data        (load_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      offset_q <= 2'b00;
      width_q  <= MEM_BYTE;
      sign_q   <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= wdata_in;
        wstrb_q  <= wstrb_in;
        we_q     <= mem_write_en;
        offset_q <= offset_in;
        width_q  <= mem_width;
        sign_q   <= sign_extend;
        rd_q     <= rd_in;
        if (!is_mem || trap) begin
          result_q <= addr;
          rd_out_q <= trap ? 5'd0 : rd_in;
        end
      end
      if ((state == REQ) && dmem_req_ready && we_q) begin
        result_q <= addr_q;
        rd_out_q <= 5'd0;
      end
      if ((state == WAIT_RSP) && dmem_rsp_valid) begin
        result_q <= load_value;
        rd_out_q <= rd_q;
      end
    end
  end

  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_we    = we_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign result     = result_q;
  assign rd_out     = rd_out_q;

endmodule
